// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and tables for the HD44780 4-bit sequencer.
// Power-on nibbles, config bytes and the slow-opcode predicate live here.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT_NIB,
    ST_CFG_HI,
    ST_CFG_LO,
    ST_IDLE,
    ST_XFER_HI,
    ST_XFER_LO
  } lcd_state_e;

  typedef enum logic [2:0] {
    TX_WAIT,
    TX_SETUP,
    TX_EHI,
    TX_GAP,
    TX_IDLE
  } tx_phase_e;

  localparam logic [7:0] CFG_BYTES [4] = '{
    8'h28, 8'h06, 8'h0C, 8'h01
  };

  localparam logic [3:0] INIT_NIBS [4] = '{
    4'h3, 4'h3, 4'h3, 4'h2
  };

  // Clear display / return home need the long settle time.
  function automatic logic is_clr_home(
    input logic       rs,
    input logic [7:0] b
  );
    return !rs && (b == 8'h01 || b == 8'h02 || b == 8'h03);
  endfunction

  function automatic int lmax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_cmd_sequencer_if.sv
// lcd_cmd_sequencer_if: byte command port, valid/ready handshake.
// master = application side, slave = LCD sequencer.
interface lcd_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rs;
  logic [7:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_rs,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_rs,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/lcd_nibble_tx.sv
// lcd_nibble_tx: one E-strobed nibble (setup, E high, gap).
// Out of reset it first burns the power-up delay on the same counter.
module lcd_nibble_tx
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC = 2,
  parameter int E_CYC     = 12,
  parameter int PWRUP_CYC = 750000,
  parameter int CW        = 21
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [3:0]    nib_i,
  input  logic          rs_i,
  input  logic [CW-1:0] gap_i,
  output logic          done_o,
  output logic          lcd_e_o,
  output logic          lcd_rs_o,
  output logic [3:0]    lcd_db_o
);

  tx_phase_e     ph_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] gap_q;
  logic          e_q;
  logic          rs_q;
  logic [3:0]    db_q;

  // Last cycle of the power-up wait or of the trailing gap
  // (or of E high when the gap is zero).
  assign done_o = (cnt_q == '0) &&
                  (ph_q == TX_WAIT || ph_q == TX_GAP ||
                   (ph_q == TX_EHI && gap_q == '0));

  assign lcd_e_o  = e_q;
  assign lcd_rs_o = rs_q;
  assign lcd_db_o = db_q;

  // Phase sequencer: every phase reloads the single down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q  <= TX_WAIT;
      cnt_q <= CW'(PWRUP_CYC - 1);
      gap_q <= '0;
      e_q   <= 1'b0;
      rs_q  <= 1'b0;
      db_q  <= '0;
    end else if (start_i) begin
      ph_q  <= TX_SETUP;
      cnt_q <= CW'(SETUP_CYC - 1);
      gap_q <= gap_i;
      e_q   <= 1'b0;
      rs_q  <= rs_i;
      db_q  <= nib_i;
    end else begin
      unique case (ph_q)
        TX_WAIT, TX_GAP: begin
          if (cnt_q == '0) ph_q <= TX_IDLE;
          else cnt_q <= cnt_q - CW'(1);
        end
        TX_SETUP: begin
          if (cnt_q == '0) begin
            ph_q  <= TX_EHI;
            e_q   <= 1'b1;
            cnt_q <= CW'(E_CYC - 1);
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        TX_EHI: begin
          if (cnt_q == '0) begin
            e_q <= 1'b0;
            if (gap_q == '0) begin
              ph_q <= TX_IDLE;
            end else begin
              ph_q  <= TX_GAP;
              cnt_q <= gap_q - CW'(1);
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        TX_IDLE: ;
        default: ph_q <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer: HD44780 4-bit init + byte command sequencer.
// Runs power-on init/config, then streams bytes as nibble pairs.
module lcd_cmd_sequencer
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC   = 2,
  parameter int E_CYC       = 12,
  parameter int NIB_GAP_CYC = 50,
  parameter int CMD_GAP_CYC = 2000,
  parameter int CLR_GAP_CYC = 82000,
  parameter int PWRUP_CYC   = 750000,
  parameter int INIT_W1_CYC = 205000,
  parameter int INIT_W2_CYC = 5000,
  parameter int INIT_W3_CYC = 2000
) (
  input  logic                 clk,
  input  logic                 rst,
  lcd_cmd_sequencer_if.slave   cmd,
  output logic                 init_done,
  output logic                 busy,
  output logic                 lcd_e,
  output logic                 lcd_rs,
  output logic                 lcd_rw,
  output logic [3:0]           lcd_db
);

  localparam int MAXP = lmax(
    lmax(lmax(SETUP_CYC, E_CYC),
         lmax(NIB_GAP_CYC, CMD_GAP_CYC)),
    lmax(lmax(CLR_GAP_CYC, PWRUP_CYC),
         lmax(lmax(INIT_W1_CYC, INIT_W2_CYC),
              INIT_W3_CYC)));
  localparam int CW = $clog2(MAXP) + 1;

  lcd_state_e    state_q;
  logic [1:0]    idx_q;
  logic [1:0]    idx_nx;
  logic [7:0]    byte_q;
  logic          brs_q;
  logic          ready_q;
  logic          done_q;

  logic          hs;
  logic          tx_start;
  logic [3:0]    tx_nib;
  logic          tx_rs;
  logic [CW-1:0] tx_gap;
  logic [CW-1:0] fin_gap;
  logic          tx_done;

  function automatic logic [CW-1:0] init_gap(
    input logic [1:0] i
  );
    unique case (i)
      2'd0:    return CW'(INIT_W1_CYC);
      2'd1:    return CW'(INIT_W2_CYC);
      default: return CW'(INIT_W3_CYC);
    endcase
  endfunction

  assign idx_nx  = idx_q + 2'd1;
  assign hs      = cmd.cmd_valid & ready_q;
  assign fin_gap = is_clr_home(brs_q, byte_q) ?
                   CW'(CLR_GAP_CYC) : CW'(CMD_GAP_CYC);

  assign cmd.cmd_ready = ready_q;
  assign busy          = ~ready_q;
  assign init_done     = done_q;
  assign lcd_rw        = 1'b0;

  // Pick the next nibble so it starts right after the current gap.
  always_comb begin
    tx_start = 1'b0;
    tx_nib   = '0;
    tx_rs    = 1'b0;
    tx_gap   = '0;
    unique case (state_q)
      ST_PWRUP: begin
        if (tx_done) begin
          tx_start = 1'b1;
          tx_nib   = INIT_NIBS[0];
          tx_gap   = init_gap(2'd0);
        end
      end
      ST_INIT_NIB: begin
        if (tx_done) begin
          tx_start = 1'b1;
          if (idx_q == 2'd3) begin
            tx_nib = CFG_BYTES[0][7:4];
            tx_gap = CW'(NIB_GAP_CYC);
          end else begin
            tx_nib = INIT_NIBS[idx_nx];
            tx_gap = init_gap(idx_nx);
          end
        end
      end
      ST_CFG_HI, ST_XFER_HI: begin
        if (tx_done) begin
          tx_start = 1'b1;
          tx_nib   = byte_q[3:0];
          tx_rs    = brs_q;
          tx_gap   = fin_gap;
        end
      end
      ST_CFG_LO: begin
        if (tx_done && idx_q != 2'd3) begin
          tx_start = 1'b1;
          tx_nib   = CFG_BYTES[idx_nx][7:4];
          tx_gap   = CW'(NIB_GAP_CYC);
        end
      end
      ST_IDLE: begin
        if (hs) begin
          tx_start = 1'b1;
          tx_nib   = cmd.cmd_data[7:4];
          tx_rs    = cmd.cmd_rs;
          tx_gap   = CW'(NIB_GAP_CYC);
        end
      end
      default: ;
    endcase
  end

  // Main sequencer: init nibbles, config bytes, then user bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_PWRUP;
      idx_q   <= '0;
      byte_q  <= '0;
      brs_q   <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_PWRUP: begin
          if (tx_done) begin
            state_q <= ST_INIT_NIB;
            idx_q   <= '0;
          end
        end
        ST_INIT_NIB: begin
          if (tx_done) begin
            if (idx_q == 2'd3) begin
              state_q <= ST_CFG_HI;
              idx_q   <= '0;
              byte_q  <= CFG_BYTES[0];
              brs_q   <= 1'b0;
            end else begin
              idx_q <= idx_nx;
            end
          end
        end
        ST_CFG_HI: begin
          if (tx_done) state_q <= ST_CFG_LO;
        end
        ST_CFG_LO: begin
          if (tx_done) begin
            if (idx_q == 2'd3) begin
              state_q <= ST_IDLE;
              ready_q <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_CFG_HI;
              idx_q   <= idx_nx;
              byte_q  <= CFG_BYTES[idx_nx];
            end
          end
        end
        ST_IDLE: begin
          if (hs) begin
            state_q <= ST_XFER_HI;
            ready_q <= 1'b0;
            byte_q  <= cmd.cmd_data;
            brs_q   <= cmd.cmd_rs;
          end
        end
        ST_XFER_HI: begin
          if (tx_done) state_q <= ST_XFER_LO;
        end
        ST_XFER_LO: begin
          if (tx_done) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= ST_PWRUP;
      endcase
    end
  end

  lcd_nibble_tx #(
    .SETUP_CYC (SETUP_CYC),
    .E_CYC     (E_CYC),
    .PWRUP_CYC (PWRUP_CYC),
    .CW        (CW)
  ) u_tx (
    .clk      (clk),
    .rst      (rst),
    .start_i  (tx_start),
    .nib_i    (tx_nib),
    .rs_i     (tx_rs),
    .gap_i    (tx_gap),
    .done_o   (tx_done),
    .lcd_e_o  (lcd_e),
    .lcd_rs_o (lcd_rs),
    .lcd_db_o (lcd_db)
  );

endmodule

// File: doc/lcd_cmd_sequencer.md
# lcd_cmd_sequencer

Parametrised HD44780-class LCD driver for the 4-bit bus. After reset it runs the power-on initialisation and configuration sequence on its own, then accepts arbitrary command and character bytes over a valid/ready port. Each byte is split into two E-strobed nibbles with programmable setup, pulse and gap timing. It sits between the application logic (rotary-encoder display formatter) and the LCD pins, and replaces the hard-coded message FSM.

## Interface
Parameters:
- SETUP_CYC, 2: cycles that RS and DB must be stable before E rises (≥40 ns).
- E_CYC, 12: E high width in cycles (≥230 ns at 50 MHz).
- NIB_GAP_CYC, 50: wait after the upper nibble, measured from E fall.
- CMD_GAP_CYC, 2000: wait after the lower nibble of a normal byte (≥40 µs).
- CLR_GAP_CYC, 82000: wait after the lower nibble of clear/home (≥1.64 ms).
- PWRUP_CYC, 750000: delay from reset release to the first init nibble (15 ms).
- INIT_W1_CYC, 205000: wait after the first 0x3 init nibble (4.1 ms).
- INIT_W2_CYC, 5000: wait after the second 0x3 init nibble (100 µs).
- INIT_W3_CYC, 2000: wait after the third 0x3 init nibble and after the 0x2 nibble.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset, asynchronous, active-high.
- cmd_valid, in, 1: a byte is offered.
- cmd_ready, out, 1: the block accepts a byte this cycle.
- cmd_rs, in, 1: 0 = instruction, 1 = data (character).
- cmd_data, in, 8: byte to send.
- init_done, out, 1: sticky high once the configuration sequence completes.
- busy, out, 1: high whenever cmd_ready is low.
- lcd_e, out, 1: enable strobe.
- lcd_rs, out, 1: register select.
- lcd_rw, out, 1: tied 0 (write only).
- lcd_db, out, 4: data nibble (DB7..DB4).

## Operation
- Reset values: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_db=0, cmd_ready=0, init_done=0, busy=1. Reset mid-operation aborts any transfer immediately and restarts from PWRUP.
- States: PWRUP → INIT_NIB (4 single nibbles) → CFG (4 bytes) → IDLE ⇄ XFER_HI → XFER_LO.
- PWRUP: wait PWRUP_CYC cycles with all outputs at reset values.
- INIT_NIB: single nibbles with RS=0, in this order:
  - 0x3, then INIT_W1_CYC;
  - 0x3, then INIT_W2_CYC;
  - 0x3, then INIT_W3_CYC;
  - 0x2, then INIT_W3_CYC.
- CFG: full bytes with RS=0, in order 0x28, 0x06, 0x0C, 0x01. These use the same byte path and gap rules as user bytes.
- After the last CFG byte's gap: init_done=1, enter IDLE.
- IDLE: cmd_ready=1. A handshake (cmd_valid & cmd_ready) captures cmd_rs and cmd_data. cmd_ready drops the next cycle. cmd_valid while not ready is ignored and must be held by the sender.
- Nibble transfer (shared by all phases), from the first cycle:
  - drive lcd_db and lcd_rs, lcd_e=0, for SETUP_CYC cycles;
  - lcd_e=1 for E_CYC cycles;
  - lcd_e=0 with lcd_db and lcd_rs held for the gap count.
- Byte = upper nibble with NIB_GAP_CYC, then lower nibble with the final gap.
- Final gap is CLR_GAP_CYC when RS=0 and the byte is 0x01, 0x02 or 0x03; otherwise it is CMD_GAP_CYC.
- lcd_db and lcd_rs keep their last values in IDLE; they change only at the start of a setup phase.

## Timing
- One down-counter, width $clog2 of the largest parameter + 1, is reloaded at each phase start. A phase of N cycles lasts exactly N cycles. N=0 is illegal for every parameter except NIB_GAP_CYC.
- Byte latency: handshake at cycle T; the upper-nibble setup starts at T+1; cmd_ready reasserts at T+1+2·(SETUP_CYC+E_CYC)+NIB_GAP_CYC+gap.
- Back-to-back bytes: the earliest next handshake is the cycle cmd_ready returns. There is no extra idle cycle.
- The first lcd_e rise happens at PWRUP_CYC+SETUP_CYC cycles after reset release.

## Structure
- Package lcd_pkg holds:
  - the state enum;
  - the CFG byte constants (0x28, 0x06, 0x0C, 0x01) and the init nibble list (3, 3, 3, 2);
  - the clear/home opcode predicate function.
- Sub-module lcd_nibble_tx performs one nibble: start/nibble/rs/gap in, done pulse out. It owns the counter and drives lcd_e. The top FSM only sequences the nibbles.

## Test plan
All runs use SETUP=2, E=3, NIB_GAP=4, CMD_GAP=10, CLR_GAP=30, PWRUP=20, W1=8, W2=6, W3=5.
- Reset release: first lcd_e rise at cycle 22. The E pulses carry DB 3,3,3,2 with E-fall-to-next-E-rise spacing 8+2, 6+2, 5+2. Then the pulses carry 2,8, 0,6, 0,C, 0,1 with RS=0. init_done rises when the 0x01 gap of 30 ends.
- Handshake rs=1, data=0x41 at cycle T: E pulses carry DB=4 then DB=1 with lcd_rs=1, and cmd_ready returns at T+25.
- Handshake rs=0, data=0x01: cmd_ready returns at T+45. With rs=1, data=0x01: T+25.
- cmd_valid held high for 3 bytes: exactly 3 handshakes, each one the cycle cmd_ready returns, with 6 E pulses in order.
- rst asserted during the E high of a lower nibble: lcd_e=0 in the same cycle. The full init sequence restarts, and a pending cmd_valid is not accepted before init_done.
- cmd_valid asserted during init: cmd_ready stays 0, and no user nibble appears on lcd_db until after the 0x01 config gap.
